// File: rtl/fractal_pkg.sv
// fractal_pkg: shared types and constants for the fractal kernel chain.
// Holds the fixed-point word format (signed Q4.28), iteration limits, the
// coordinate generator state encoding and the seed payload carried downstream.
package fractal_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned FRAC_WIDTH = 28;
    localparam int unsigned ITER_WIDTH = 8;
    localparam int unsigned MAX_ITER   = 255;

    typedef logic signed [31:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One seed entering the first kernel stage.
    typedef struct packed {
        fixed_t                  zr;
        fixed_t                  zi;
        fixed_t                  cr;
        fixed_t                  ci;
        logic [ITER_WIDTH-1:0]   iter;
        logic                    finished;
    } seed_t;

    // Counter width for a dimension of n; a 1-pixel dimension still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fractal_coord_axis.sv
// fractal_coord_axis: one raster axis (pixel counter plus coordinate accumulator).
// Ports:
//   clk, reset     clock, async active-high reset
//   load           latch origin/delta, counter=0, acc=origin
//   step           advance: count++/acc+=delta, or wrap to 0/origin when last
//   origin, delta  signed coordinate of index 0 and step per index
//   count          current index
//   acc            coordinate of the current index (mod 2^32 wrap)
//   last           count is at N-1
module fractal_coord_axis
    import fractal_pkg::*;
#(
    parameter int unsigned N = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     step,
    input  fixed_t                   origin,
    input  fixed_t                   delta,
    output logic [cnt_width(N)-1:0]  count,
    output fixed_t                   acc,
    output logic                     last
);

    localparam int unsigned CW = cnt_width(N);

    fixed_t origin_q;
    fixed_t delta_q;

    // Counter and accumulator; origin/delta held for the whole frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            acc      <= '0;
            origin_q <= '0;
            delta_q  <= '0;
        end else if (load) begin
            count    <= '0;
            acc      <= origin;
            origin_q <= origin;
            delta_q  <= delta;
        end else if (step) begin
            if (last) begin
                count <= '0;
                acc   <= origin_q;
            end else begin
                count <= count + CW'(1);
                acc   <= acc + delta_q;
            end
        end
    end

    assign last = (count == CW'(N - 1));

endmodule

// File: rtl/fractal_coord_gen.sv
// fractal_coord_gen: raster-order seed generator feeding the fractal kernel.
// Optional build macro: FRACTAL_JULIA_EN (Julia seeds: z = pixel coordinate,
// c = latched jr/ji). Without it, Mandelbrot seeds: z = 0, c = pixel coordinate.
// Ports:
//   clk, reset               clock, async active-high reset
//   start                    begin a frame (only honoured while idle)
//   x0, y0, dx, dy           window origin and steps, latched at start
//   jr, ji                   Julia constant (FRACTAL_JULIA_EN only), latched at start
//   busy, done               frame in progress / one-cycle end-of-frame pulse
//   out_valid, out_ready     seed handshake
//   zr_out, zi_out           initial z
//   cr_out, ci_out           c for this pixel
//   iter_out, finished_out   always 0
//   sof, eol, eof            frame/line markers, qualified by out_valid
module fractal_coord_gen
    import fractal_pkg::*;
#(
    parameter int unsigned H_PIXELS = 1920,
    parameter int unsigned V_PIXELS = 1080
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  x0,
    input  logic [DATA_WIDTH-1:0]  y0,
    input  logic [DATA_WIDTH-1:0]  dx,
    input  logic [DATA_WIDTH-1:0]  dy,
`ifdef FRACTAL_JULIA_EN
    input  logic [DATA_WIDTH-1:0]  jr,
    input  logic [DATA_WIDTH-1:0]  ji,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  zr_out,
    output logic [DATA_WIDTH-1:0]  zi_out,
    output logic [DATA_WIDTH-1:0]  cr_out,
    output logic [DATA_WIDTH-1:0]  ci_out,
    output logic [ITER_WIDTH-1:0]  iter_out,
    output logic                   finished_out,
    output logic                   sof,
    output logic                   eol,
    output logic                   eof
);

    if (H_PIXELS == 0 || V_PIXELS == 0) begin : g_bad_size
        $error("fractal_coord_gen: H_PIXELS and V_PIXELS must be nonzero");
    end

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_RUN  = 2'(RUN);
    localparam logic [1:0] S_DONE = 2'(DONE);

    localparam int unsigned XW = cnt_width(H_PIXELS);
    localparam int unsigned YW = cnt_width(V_PIXELS);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic          load_c;
    logic          step_x_c;
    logic          step_y_c;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          x_last;
    logic          y_last;
    fixed_t        x_acc;
    fixed_t        y_acc;
    seed_t         seed_c;

    fractal_coord_axis #(.N(H_PIXELS)) u_x_axis (
        .clk    (clk),
        .reset  (reset),
        .load   (load_c),
        .step   (step_x_c),
        .origin (fixed_t'(x0)),
        .delta  (fixed_t'(dx)),
        .count  (x_cnt),
        .acc    (x_acc),
        .last   (x_last)
    );

    // The y axis only moves when the x axis wraps at end of line.
    fractal_coord_axis #(.N(V_PIXELS)) u_y_axis (
        .clk    (clk),
        .reset  (reset),
        .load   (load_c),
        .step   (step_y_c),
        .origin (fixed_t'(y0)),
        .delta  (fixed_t'(dy)),
        .count  (y_cnt),
        .acc    (y_acc),
        .last   (y_last)
    );

    // State register plus registered handshake/status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            busy      <= (state_nx == S_RUN);
            out_valid <= (state_nx == S_RUN);
            done      <= (state_nx == S_DONE);
        end
    end

    // Next state and axis controls; a stalled handshake leaves everything held.
    always_comb begin
        state_nx = state;
        load_c   = 1'b0;
        step_x_c = 1'b0;
        step_y_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load_c   = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (out_ready) begin
                    step_x_c = 1'b1;
                    if (x_last) begin
                        step_y_c = 1'b1;
                        if (y_last) begin
                            state_nx = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef FRACTAL_JULIA_EN
    fixed_t jr_q;
    fixed_t ji_q;

    // Julia constant, captured with the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jr_q <= '0;
            ji_q <= '0;
        end else if (load_c) begin
            jr_q <= fixed_t'(jr);
            ji_q <= fixed_t'(ji);
        end
    end

    assign seed_c = '{zr: x_acc, zi: y_acc, cr: jr_q, ci: ji_q,
                      iter: '0, finished: 1'b0};
`else
    assign seed_c = '{zr: '0, zi: '0, cr: x_acc, ci: y_acc,
                      iter: '0, finished: 1'b0};
`endif

    assign zr_out       = seed_c.zr;
    assign zi_out       = seed_c.zi;
    assign cr_out       = seed_c.cr;
    assign ci_out       = seed_c.ci;
    assign iter_out     = seed_c.iter;
    assign finished_out = seed_c.finished;

    assign sof = out_valid && (x_cnt == '0) && (y_cnt == '0);
    assign eol = out_valid && x_last;
    assign eof = out_valid && x_last && y_last;

endmodule

// File: tb/tb_fractal_coord_gen.sv
// tb_fractal_coord_gen: self-checking bench for fractal_coord_gen on a 4x3 frame.
// Build with FRACTAL_JULIA_EN defined to exercise the Julia seed variant.
module tb_fractal_coord_gen;

    localparam int H = 4;
    localparam int V = 3;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] x0, y0, dx, dy;
    logic        busy, done, out_valid, out_ready;
    logic [31:0] zr_out, zi_out, cr_out, ci_out;
    logic [7:0]  iter_out;
    logic        finished_out, sof, eol, eof;
`ifdef FRACTAL_JULIA_EN
    logic [31:0] jr, ji;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    // Walk coordinates and markers captured per handshaken pixel.
    logic [31:0] got_wr [N];
    logic [31:0] got_wi [N];
    logic [2:0]  got_m  [N];

    typedef struct {
        logic [31:0] cr;
        logic [31:0] ci;
        logic [2:0]  m;   // {sof, eol, eof}
    } vec_t;
    vec_t tbl [N];

    always #5 clk = ~clk;

    fractal_coord_gen #(.H_PIXELS(H), .V_PIXELS(V)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .x0           (x0),
        .y0           (y0),
        .dx           (dx),
        .dy           (dy),
`ifdef FRACTAL_JULIA_EN
        .jr           (jr),
        .ji           (ji),
`endif
        .busy         (busy),
        .done         (done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .zr_out       (zr_out),
        .zi_out       (zi_out),
        .cr_out       (cr_out),
        .ci_out       (ci_out),
        .iter_out     (iter_out),
        .finished_out (finished_out),
        .sof          (sof),
        .eol          (eol),
        .eof          (eof)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_marks"}, 32'({sof, eol, eof}), 0);
        check({tag, "_cr"}, cr_out, 0);
        check({tag, "_ci"}, ci_out, 0);
        check({tag, "_zr"}, zr_out, 0);
        check({tag, "_zi"}, zi_out, 0);
    endtask

    // Runs one frame and checks every sample against the arithmetic model.
    task automatic run_frame(input logic [31:0] ax0, input logic [31:0] ay0,
                             input logic [31:0] adx, input logic [31:0] ady,
                             input bit rand_ready, input int restart_at, input int reset_at);
        int p = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [31:0] h_cr = 0, h_ci = 0, h_zr = 0, h_zi = 0;
        logic [2:0]  h_m = 0;
        logic [31:0] wr, wi, e_cr, e_ci, e_zr, e_zi;
        int xi, yi;
        x0 = ax0; y0 = ay0; dx = adx; dy = ady;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("first_valid", 32'(out_valid), 1);
        while (p < N && cyc < 1000) begin
            if (p == reset_at) begin
                reset = 1'b1;
                #1;
                check_zero("midreset");
                reset = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    tick();
                    check("midreset_nodone", 32'(done), 0);
                    check("midreset_idle", 32'(out_valid | busy), 0);
                end
                return;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            xi = p % H;
            yi = p / H;
            wr = ax0 + 32'(xi) * adx;
            wi = ay0 + 32'(yi) * ady;
`ifdef FRACTAL_JULIA_EN
            e_zr = wr; e_zi = wi; e_cr = jr; e_ci = ji;
`else
            e_zr = 0;  e_zi = 0;  e_cr = wr; e_ci = wi;
`endif
            if (stalled) begin
                check("stall_cr", cr_out, h_cr);
                check("stall_ci", ci_out, h_ci);
                check("stall_zr", zr_out, h_zr);
                check("stall_zi", zi_out, h_zi);
                check("stall_marks", 32'({sof, eol, eof}), 32'(h_m));
            end
            check("valid", 32'(out_valid), 1);
            check("busy", 32'(busy), 1);
            check("done_low", 32'(done), 0);
            check("cr", cr_out, e_cr);
            check("ci", ci_out, e_ci);
            check("zr", zr_out, e_zr);
            check("zi", zi_out, e_zi);
            check("iter_fin", 32'({iter_out, finished_out}), 0);
            check("marks", 32'({sof, eol, eof}),
                  32'({p == 0, xi == H - 1, p == N - 1}));
            if (p == restart_at) begin
                start = 1'b1;
                x0 = '0;
            end else begin
                start = 1'b0;
            end
            if (out_ready) begin
`ifdef FRACTAL_JULIA_EN
                got_wr[p] = zr_out; got_wi[p] = zi_out;
`else
                got_wr[p] = cr_out; got_wi[p] = ci_out;
`endif
                got_m[p] = {sof, eol, eof};
                p++;
            end
            stalled = !out_ready;
            h_cr = cr_out; h_ci = ci_out; h_zr = zr_out; h_zi = zi_out;
            h_m = {sof, eol, eof};
            tick();
            cyc++;
        end
        start = 1'b0;
        check("frame_timeout", 32'(p), 32'(N));
        if (!rand_ready) check("consecutive_cycles", 32'(cyc), 32'(N));
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_valid", 32'(out_valid), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("after_done_done", 32'(done), 0);
        check("after_done_valid", 32'(out_valid), 0);
        tick();
        check("start_on_done_ignored", 32'(out_valid | busy), 0);
    endtask

    // Compares the captured walk against the hand-computed 4x3 window table.
    task automatic check_table(input string tag);
        for (int i = 0; i < N; i++) begin
            check({tag, "_tbl_wr"}, got_wr[i], tbl[i].cr);
            check({tag, "_tbl_wi"}, got_wi[i], tbl[i].ci);
            check({tag, "_tbl_m"}, 32'(got_m[i]), 32'(tbl[i].m));
        end
    endtask

    initial begin
        // -2.0..-1.25 by 0.25 across, -1.0..0.0 by 0.5 down.
        tbl[0]  = '{32'hE000_0000, 32'hF000_0000, 3'b100};
        tbl[1]  = '{32'hE400_0000, 32'hF000_0000, 3'b000};
        tbl[2]  = '{32'hE800_0000, 32'hF000_0000, 3'b000};
        tbl[3]  = '{32'hEC00_0000, 32'hF000_0000, 3'b010};
        tbl[4]  = '{32'hE000_0000, 32'hF800_0000, 3'b000};
        tbl[5]  = '{32'hE400_0000, 32'hF800_0000, 3'b000};
        tbl[6]  = '{32'hE800_0000, 32'hF800_0000, 3'b000};
        tbl[7]  = '{32'hEC00_0000, 32'hF800_0000, 3'b010};
        tbl[8]  = '{32'hE000_0000, 32'h0000_0000, 3'b000};
        tbl[9]  = '{32'hE400_0000, 32'h0000_0000, 3'b000};
        tbl[10] = '{32'hE800_0000, 32'h0000_0000, 3'b000};
        tbl[11] = '{32'hEC00_0000, 32'h0000_0000, 3'b011};

        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        x0 = '0; y0 = '0; dx = '0; dy = '0;
`ifdef FRACTAL_JULIA_EN
        jr = 32'hFCCC_CCCD; ji = 32'h0A3D_70A4;
`endif
        tick();
        tick();
        check_zero("reset");
        reset = 1'b0;
        tick();
        check_zero("idle");

        run_frame(32'hE000_0000, 32'hF000_0000, 32'h0400_0000, 32'h0800_0000, 0, -1, -1);
        check_table("s1");

        run_frame(32'hE000_0000, 32'hF000_0000, 32'h0400_0000, 32'h0800_0000, 1, -1, -1);
        check_table("s2");

        run_frame(32'hE000_0000, 32'hF000_0000, 32'h0400_0000, 32'h0800_0000, 0, 5, -1);
        check_table("s3");

        run_frame(32'hE000_0000, 32'hF000_0000, 32'h0400_0000, 32'h0800_0000, 1, -1, 6);
        run_frame(32'hE000_0000, 32'hF000_0000, 32'h0400_0000, 32'h0800_0000, 0, -1, -1);
        check_table("s4");

        run_frame(32'h7FFF_FFF0, 32'h0, 32'h0000_0010, 32'h0, 0, -1, -1);
        check("wrap_px1", got_wr[1], 32'h8000_0000);

        for (int r = 0; r < 4; r++) begin
`ifdef FRACTAL_JULIA_EN
            jr = $urandom; ji = $urandom;
`endif
            run_frame($urandom, $urandom, $urandom, $urandom, 1, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
